// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction store.
// Frames a UART byte stream (SYNC, COUNT, N x 4-byte big-endian words, CHK) into
// instruction words and writes them sequentially into the instruction RAM. The CPU is
// held in reset while a frame is in flight and released once the checksum matches.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   RxData   - received byte
//   RxValid  - one-cycle strobe qualifying RxData
//   WeRAM    - instruction RAM write enable (one-cycle pulse)
//   AddrRAM  - instruction RAM write address
//   DataRAM  - instruction RAM write data
//   CpuHold  - holds the CPU in reset while high
//   Done     - last frame loaded with a good checksum (sticky)
//   Error    - last frame aborted by bad checksum or timeout (sticky)
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 29,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              WeRAM,
    output logic [ADDR_W-1:0] AddrRAM,
    output logic [DATA_W-1:0] DataRAM,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        st_idle,
        st_count,
        st_word,
        st_check,
        st_done,
        st_err
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   nwords;     // one extra bit so COUNT=0 can mean 2^ADDR_W
    logic [ADDR_W:0]   wcnt;
    logic [1:0]        byte_idx;
    logic [7:0]        chk;
    logic [23:0]       shreg;      // first three bytes of the word being assembled
    logic [TW-1:0]     timer;
    logic              active;
    logic              expire;
    logic [DATA_W-1:0] word_trunc;

    always_comb begin
        active     = (state == st_count) || (state == st_word) || (state == st_check);
        // A byte in the expiry cycle wins over the timeout.
        expire     = !RxValid && (timer == TW'(TIMEOUT - 1));
        word_trunc = DATA_W'({shreg, RxData});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= st_idle;
            WeRAM    <= 1'b0;
            AddrRAM  <= '0;
            DataRAM  <= '0;
            CpuHold  <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            nwords   <= '0;
            wcnt     <= '0;
            byte_idx <= '0;
            chk      <= '0;
            shreg    <= '0;
            timer    <= '0;
        end else begin
            WeRAM <= 1'b0;

            if (active) begin
                timer <= RxValid ? '0 : timer + TW'(1);
            end

            if (active && expire) begin
                state <= st_err;
                Error <= 1'b1;
            end else begin
                case (state)
                    st_idle, st_done, st_err: begin
                        if (RxValid && (RxData == SYNC_BYTE)) begin
                            state   <= st_count;
                            CpuHold <= 1'b1;
                            Done    <= 1'b0;
                            Error   <= 1'b0;
                            AddrRAM <= '0;
                            chk     <= '0;
                            timer   <= '0;
                        end
                    end

                    st_count: begin
                        if (RxValid) begin
                            nwords   <= (RxData == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                         : (ADDR_W + 1)'(RxData);
                            wcnt     <= '0;
                            byte_idx <= '0;
                            state    <= st_word;
                        end
                    end

                    st_word: begin
                        // Cycle after the pulse: advance address and word count.
                        if (WeRAM) begin
                            AddrRAM <= AddrRAM + ADDR_W'(1);
                            wcnt    <= wcnt + (ADDR_W + 1)'(1);
                            if ((wcnt + (ADDR_W + 1)'(1)) == nwords) begin
                                state <= st_check;
                            end
                        end
                        if (RxValid) begin
                            shreg    <= {shreg[15:0], RxData};
                            chk      <= chk + RxData;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                WeRAM   <= 1'b1;
                                DataRAM <= word_trunc;
                            end
                        end
                    end

                    st_check: begin
                        if (RxValid) begin
                            if (RxData == chk) begin
                                state   <= st_done;
                                Done    <= 1'b1;
                                CpuHold <= 1'b0;
                            end else begin
                                state <= st_err;
                                Error <= 1'b1;
                            end
                        end
                    end

                    default: state <= st_idle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 29;

    logic              clk;
    logic              rst_n;
    logic [7:0]        RxData;
    logic              RxValid;
    logic              WeRAM;
    logic [ADDR_W-1:0] AddrRAM;
    logic [DATA_W-1:0] DataRAM;
    logic              CpuHold;
    logic              Done;
    logic              Error;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed write pulses (one entry per cycle with WeRAM high).
    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    logic [7:0]        fq[$];

    prog_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (50)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RxData (RxData),
        .RxValid(RxValid),
        .WeRAM  (WeRAM),
        .AddrRAM(AddrRAM),
        .DataRAM(DataRAM),
        .CpuHold(CpuHold),
        .Done   (Done),
        .Error  (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (WeRAM === 1'b1) begin
            wa.push_back(AddrRAM);
            wd.push_back(DataRAM);
        end
    end

    // Byte is sampled at the posedge inside the task; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RxData  = b;
        RxValid = 1'b1;
        @(negedge clk);
        RxValid = 1'b0;
    endtask

    task automatic send_fq();
        foreach (fq[i]) send_byte(fq[i]);
        fq.delete();
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(1);
        wa.delete();
        wd.delete();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        RxValid = 1'b0;
        RxData  = 8'h00;
        wait_neg(3);
        n_checks++;
        if ({WeRAM, CpuHold, Done, Error} !== 4'b0000)
            $display("FAIL reset_flags: got We/Hold/Done/Err=%b want 0000",
                     {WeRAM, CpuHold, Done, Error});
        else n_pass++;
        n_checks++;
        if (AddrRAM !== 8'd0 || DataRAM !== 29'd0)
            $display("FAIL reset_bus: got addr=%h data=%h want 0/0", AddrRAM, DataRAM);
        else n_pass++;
        rst_n = 1'b1;
        wait_neg(1);
    endtask

    task automatic test_basic();
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        n_checks++;
        if (CpuHold !== 1'b1) $display("FAIL basic_hold_after_sync: got %b want 1", CpuHold);
        else n_pass++;
        fq = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h01, 8'h15, 8'h00, 8'h00, 8'h07, 8'h1E};
        send_fq();
        n_checks++;
        if (wa.size() != 2) $display("FAIL basic_pulses: got %0d want 2", wa.size());
        else if (wa[0] !== 8'd0 || wd[0] !== 29'h01000001 || wa[1] !== 8'd1 ||
                 wd[1] !== 29'h15000007)
            $display("FAIL basic_writes: got %h:%h %h:%h want 00:01000001 01:15000007",
                     wa[0], wd[0], wa[1], wd[1]);
        else n_pass++;
        n_checks++;
        if ({Done, CpuHold, Error} !== 3'b100 || AddrRAM !== 8'd2)
            $display("FAIL basic_done: got D/H/E=%b addr=%h want 100 addr=02",
                     {Done, CpuHold, Error}, AddrRAM);
        else n_pass++;
    endtask

    task automatic test_truncate();
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_fq();
        n_checks++;
        if (wa.size() != 1 || wd[0] !== 29'h1F000000 || wa[0] !== 8'd0)
            $display("FAIL truncate: got n=%0d data=%h want n=1 data=1F000000",
                     wa.size(), wd.size() > 0 ? wd[0] : 29'h0);
        else n_pass++;
        n_checks++;
        if ({Done, Error} !== 2'b10) $display("FAIL truncate_done: got D/E=%b want 10",
                                              {Done, Error});
        else n_pass++;
    endtask

    task automatic test_bad_chk();
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h01, 8'h15, 8'h00, 8'h00, 8'h07, 8'h1F};
        send_fq();
        n_checks++;
        if (wa.size() != 2) $display("FAIL badchk_pulses: got %0d want 2", wa.size());
        else n_pass++;
        n_checks++;
        if ({Error, Done, CpuHold} !== 3'b101)
            $display("FAIL badchk_flags: got E/D/H=%b want 101", {Error, Done, CpuHold});
        else n_pass++;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09};
        send_fq();
        n_checks++;
        if ({Error, Done, CpuHold} !== 3'b010)
            $display("FAIL badchk_recover: got E/D/H=%b want 010", {Error, Done, CpuHold});
        else n_pass++;
    endtask

    task automatic test_full();
        int bad;
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'(i));
        end
        wait_neg(2);
        n_checks++;
        if (wa.size() != 256) $display("FAIL full_pulses: got %0d want 256", wa.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 8'(i) || wd[i] !== 29'(i)) bad++;
        n_checks++;
        if (bad != 0 || wa.size() == 0)
            $display("FAIL full_order: got %0d bad entries of %0d want 0 of 256", bad, wa.size());
        else n_pass++;
        n_checks++;
        if (AddrRAM !== 8'd0) $display("FAIL full_wrap: got addr=%h want 00", AddrRAM);
        else n_pass++;
        // sum(0..255) mod 256 = 0x80
        send_byte(8'h80);
        n_checks++;
        if ({Done, Error, CpuHold} !== 3'b100)
            $display("FAIL full_done: got D/E/H=%b want 100", {Done, Error, CpuHold});
        else n_pass++;
    endtask

    task automatic test_timeout();
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
        send_fq();
        wait_neg(49);
        n_checks++;
        if (Error !== 1'b0) $display("FAIL timeout_early: got Error=%b at 49 want 0", Error);
        else n_pass++;
        wait_neg(1);
        n_checks++;
        if ({Error, CpuHold, Done} !== 3'b110 || wa.size() != 0)
            $display("FAIL timeout_at50: got E/H/D=%b pulses=%0d want 110 pulses=0",
                     {Error, CpuHold, Done}, wa.size());
        else n_pass++;

        // Byte landing exactly on the expiry cycle keeps the frame alive.
        fq = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
        send_fq();
        wait_neg(48);
        send_byte(8'hCC);
        wait_neg(5);
        n_checks++;
        if (Error !== 1'b0) $display("FAIL timeout_byte_wins: got Error=%b want 0", Error);
        else n_pass++;
        send_byte(8'hDD);
        send_byte(8'h0E);
        n_checks++;
        if (wa.size() != 1 || wd[0] !== 29'h0ABBCCDD || {Done, Error} !== 2'b10)
            $display("FAIL timeout_complete: got n=%0d data=%h D/E=%b want 1 0ABBCCDD 10",
                     wa.size(), wd.size() > 0 ? wd[0] : 29'h0, {Done, Error});
        else n_pass++;
    endtask

    task automatic test_idle_ignore();
        do_reset();
        fq = '{8'h00, 8'hFF, 8'h3C};
        send_fq();
        n_checks++;
        if ({WeRAM, CpuHold, Done, Error} !== 4'b0000 || AddrRAM !== 8'd0 ||
            DataRAM !== 29'd0 || wa.size() != 0)
            $display("FAIL idle_ignore: got We/H/D/E=%b addr=%h data=%h want all 0",
                     {WeRAM, CpuHold, Done, Error}, AddrRAM, DataRAM);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send_fq();
        n_checks++;
        if (CpuHold !== 1'b1 || AddrRAM !== 8'd1 || wa.size() != 1)
            $display("FAIL midreset_pre: got H=%b addr=%h n=%0d want 1 01 1",
                     CpuHold, AddrRAM, wa.size());
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({WeRAM, CpuHold, Done, Error} !== 4'b0000 || AddrRAM !== 8'd0 || DataRAM !== 29'd0)
            $display("FAIL midreset_async: got We/H/D/E=%b addr=%h data=%h want all 0",
                     {WeRAM, CpuHold, Done, Error}, AddrRAM, DataRAM);
        else n_pass++;
        wait_neg(2);
        rst_n = 1'b1;
        send_byte(8'hDE);
        send_byte(8'hF0);
        wait_neg(3);
        n_checks++;
        if (wa.size() != 1 || CpuHold !== 1'b0)
            $display("FAIL midreset_nopulse: got n=%0d H=%b want 1 0", wa.size(), CpuHold);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_bad_chk();
        test_full();
        test_timeout();
        test_idle_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 256 x 29-bit instruction store. The CPU's instruction port reads that store asynchronously by 8-bit address.
- Takes a byte stream from the UART receiver, frames it into 29-bit instruction words and writes them sequentially into the instruction RAM.
- Holds the CPU while loading and releases it once a checksummed image has been fully written.

Parameters:
- ADDR_W, 8, instruction address width; depth is 2^ADDR_W.
- DATA_W, 29, instruction word width; must be ≤ 32.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 100000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- RxData, input, 8: received byte.
- RxValid, input, 1: one-cycle strobe; RxData is valid in that cycle.
- WeRAM, output, 1: instruction RAM write enable, one-cycle pulse.
- AddrRAM, output, ADDR_W: write address.
- DataRAM, output, DATA_W: write data.
- CpuHold, output, 1: holds the CPU in reset while high.
- Done, output, 1: last frame loaded with a good checksum.
- Error, output, 1: last frame aborted (bad checksum or timeout).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE.
  - WeRAM=0, AddrRAM=0, DataRAM=0, CpuHold=0, Done=0, Error=0.
  - Internal word count, byte index, checksum and timer all cleared.
  - Reset mid-frame abandons the frame; no further writes occur.
- Frame format: SYNC_BYTE, COUNT, then N words, then CHK.
  - N = COUNT, except COUNT=0 means N=2^ADDR_W.
  - Each word is 4 bytes, big-endian. The word value is the low DATA_W bits of the 32-bit concatenation; upper bits are discarded.
  - CHK = 8-bit wrapping sum of all word bytes. SYNC and COUNT are not included.
- States:
  - IDLE / DONE / ERR: on RxValid with RxData==SYNC_BYTE:
    - go to COUNT;
    - set CpuHold=1, clear Done and Error;
    - AddrRAM=0, checksum=0.
    - Any other byte is ignored, and Done/Error/CpuHold keep their values.
  - COUNT: on RxValid, latch N, byte index=0, go to WORD.
  - WORD: each RxValid shifts the byte into the assembly register and adds it to the checksum.
    - On the 4th byte, the next cycle drives WeRAM=1 for exactly one cycle, with DataRAM=assembled word and AddrRAM=current address.
    - AddrRAM increments (wrapping at 2^ADDR_W) in the cycle after the pulse.
    - After the Nth write, go to CHECK.
  - CHECK: on RxValid, compare the byte with the checksum.
    - Match: go to DONE, Done=1, CpuHold=0.
    - Mismatch: go to ERR, Error=1, CpuHold stays 1.
  - A SYNC_BYTE value received inside COUNT/WORD/CHECK is treated as data; there is no resync mid-frame.
- Timeout:
  - Applies in COUNT, WORD and CHECK. The timer resets on every RxValid.
  - When the timer reaches TIMEOUT cycles without RxValid: go to ERR, Error=1, CpuHold stays 1.
  - If RxValid arrives in the same cycle the timer expires, the byte wins and no timeout is taken.
- RxValid is never back-pressured. Bytes are at least 2 clk apart (UART rate), so a write pulse never overlaps byte acceptance.
- Done and Error are mutually exclusive and sticky until the next SYNC_BYTE or reset.
- WeRAM is never asserted outside WORD.

Test Plan:
- Bytes A5 02 01 00 00 01 15 00 00 07 1E:
  - write addr0=0x01000001, then addr1=0x15000007, one WeRAM pulse each;
  - then Done=1, CpuHold=0, Error=0.
- Word bytes FF 00 00 00 (N=1, CHK=FF): DataRAM=0x1F000000, confirming the top 3 bits are dropped.
- Same frame as the first scenario with CHK=1F: both writes occur, then Error=1, Done=0, CpuHold=1. A following good frame clears Error and sets Done.
- COUNT=00, then 256 words with data = index:
  - 256 pulses on addresses 0..255 in order;
  - AddrRAM wraps to 0 afterwards;
  - Done=1 with the correct checksum.
- TIMEOUT=50, frame stalls after 2 word bytes:
  - Error=1 exactly 50 cycles after the last RxValid, with no WeRAM pulse.
  - Separately, a byte arriving on cycle 50 prevents the timeout.
- Non-sync bytes 00 FF 3C in IDLE: no state change, all outputs 0. Asserting rst_n=0 mid-WORD: all outputs 0 immediately and no pulse follows.
